uart_avalon_master: RTL

UART_AVALON_MASTER -- requirements
Module: uart_avalon_master

---
 rtl/uart_avalon_master_if.sv | 22 ++
 rtl/uart_avalon_master.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_avalon_master_if.sv
// Avalon-MM bus bundle driven by uart_avalon_master (master) and a memory-mapped slave.
interface uart_avalon_master_if #(
  parameter int AAW = 7,
  parameter int ADW = 32
);
  logic [AAW-1:0] avalon_address;
  logic           avalon_read;
  logic           avalon_write;
  logic [ADW-1:0] avalon_writedata;
  logic [ADW-1:0] avalon_readdata;
  logic           avalon_waitrequest;

  modport master (
    output avalon_address, avalon_read, avalon_write, avalon_writedata,
    input  avalon_readdata, avalon_waitrequest
  );

  modport slave (
    input  avalon_address, avalon_read, avalon_write, avalon_writedata,
    output avalon_readdata, avalon_waitrequest
  );
endinterface

// File: rtl/uart_avalon_master.sv
// UART (8N1) command bridge driving an Avalon-MM master: 0x80|addr + 4 data bytes writes, addr reads.
// Optional macro UART_AVALON_MASTER_ACK_EN: reply 0x06 on the UART after each completed write.
module uart_avalon_master #(
  parameter int N_BIT = 16,
  parameter int AAW   = 7,
  parameter int ADW   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rxd,
  output logic                 uart_txd,
  uart_avalon_master_if.master avl
);
  localparam logic [15:0] BIT_LAST = 16'(N_BIT - 1);
  localparam logic [15:0] BIT_HALF = 16'(N_BIT / 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_DATA = 3'd1,
    WRITE   = 3'd2,
    READ    = 3'd3,
    TX_DATA = 3'd4
`ifdef UART_AVALON_MASTER_ACK_EN
    , TX_ACK = 3'd5
`endif
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [AAW-1:0] addr_q, addr_d;
  logic [ADW-1:0] wdata_q, wdata_d;
  logic [ADW-1:0] rdata_q, rdata_d;
  logic           read_q, read_d;
  logic           write_q, write_d;

  logic           rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic           rx_busy_q;
  logic [15:0]    rx_cnt_q;
  logic [3:0]     rx_bit_q;
  logic [7:0]     rx_shift_q;
  logic           rx_sample_s, rx_valid_s, rx_ferr_s;

  logic           tx_busy_q;
  logic [15:0]    tx_cnt_q;
  logic [3:0]     tx_bit_q;
  logic [8:0]     tx_shift_q;
  logic           txd_q;
  logic           tx_done_s, tx_start_s;
  logic [7:0]     tx_byte_s;

  // Synchronizer runs through reset so a line already low is not taken as a fresh start edge.
  always_ff @(posedge clk) begin
    rxd_meta_q <= uart_rxd;
    rxd_sync_q <= rxd_meta_q;
    rxd_prev_q <= rxd_sync_q;
  end

  assign rx_sample_s = rx_busy_q && (rx_cnt_q == BIT_HALF);
  assign rx_valid_s  = rx_sample_s && (rx_bit_q == 4'd9) && rxd_sync_q;
  assign rx_ferr_s   = rx_sample_s && (rx_bit_q == 4'd9) && !rxd_sync_q;

  // Receiver: bit 0 is the start bit, 1..8 data (LSB first), 9 the stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_busy_q  <= 1'b0;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= 8'h00;
    end else if (!rx_busy_q) begin
      rx_cnt_q <= 16'd0;
      rx_bit_q <= 4'd0;
      if (rxd_prev_q && !rxd_sync_q) begin
        rx_busy_q <= 1'b1;
      end
    end else if (rx_sample_s && (rx_bit_q == 4'd0) && rxd_sync_q) begin
      rx_busy_q <= 1'b0;
    end else if (rx_sample_s && (rx_bit_q == 4'd9)) begin
      rx_busy_q <= 1'b0;
    end else begin
      if (rx_sample_s) begin
        rx_shift_q <= {rxd_sync_q, rx_shift_q[7:1]};
      end
      if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_q <= 16'd0;
        rx_bit_q <= rx_bit_q + 4'd1;
      end else begin
        rx_cnt_q <= rx_cnt_q + 16'd1;
      end
    end
  end

  // A start request on the last stop-bit clock chains the next frame with no idle bit.
  assign tx_done_s = tx_busy_q && (tx_cnt_q == BIT_LAST) && (tx_bit_q == 4'd9);

  // Transmitter: start bit goes out on the edge that loads the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy_q  <= 1'b0;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 4'd0;
      tx_shift_q <= 9'h1FF;
      txd_q      <= 1'b1;
    end else if (tx_start_s) begin
      tx_busy_q  <= 1'b1;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 4'd0;
      tx_shift_q <= {1'b1, tx_byte_s};
      txd_q      <= 1'b0;
    end else if (tx_done_s) begin
      tx_busy_q <= 1'b0;
      tx_cnt_q  <= 16'd0;
      tx_bit_q  <= 4'd0;
      txd_q     <= 1'b1;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_q   <= 16'd0;
        tx_bit_q   <= tx_bit_q + 4'd1;
        txd_q      <= tx_shift_q[0];
        tx_shift_q <= {1'b1, tx_shift_q[8:1]};
      end else begin
        tx_cnt_q <= tx_cnt_q + 16'd1;
      end
    end else begin
      txd_q <= 1'b1;
    end
  end

  // Frame FSM next-state and Avalon request generation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    read_d     = read_q;
    write_d    = write_q;
    tx_start_s = 1'b0;
    tx_byte_s  = 8'h00;
    case (state_q)
      IDLE: begin
        if (rx_valid_s) begin
          addr_d  = rx_shift_q[AAW-1:0];
          cnt_d   = 3'd0;
          state_d = rx_shift_q[7] ? RX_DATA : READ;
        end else begin
          state_d = IDLE;
        end
      end
      RX_DATA: begin
        if (rx_ferr_s) begin
          state_d = IDLE;
        end else if (rx_valid_s) begin
          wdata_d = {rx_shift_q, wdata_q[ADW-1:8]};
          if (cnt_q == 3'd3) begin
            cnt_d   = 3'd0;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          state_d = RX_DATA;
        end
      end
      WRITE: begin
        if (!write_q) begin
          write_d = 1'b1;
        end else if (!avl.avalon_waitrequest) begin
          write_d = 1'b0;
`ifdef UART_AVALON_MASTER_ACK_EN
          state_d = TX_ACK;
`else
          state_d = IDLE;
`endif
        end else begin
          write_d = 1'b1;
        end
      end
      READ: begin
        if (!read_q) begin
          read_d = 1'b1;
        end else if (!avl.avalon_waitrequest) begin
          read_d  = 1'b0;
          rdata_d = avl.avalon_readdata;
          cnt_d   = 3'd0;
          state_d = TX_DATA;
        end else begin
          read_d = 1'b1;
        end
      end
      TX_DATA: begin
        if ((!tx_busy_q && (cnt_q == 3'd0)) || (tx_done_s && (cnt_q != 3'd4))) begin
          tx_start_s = 1'b1;
          tx_byte_s  = rdata_q[7:0];
          rdata_d    = {8'h00, rdata_q[ADW-1:8]};
          cnt_d      = cnt_q + 3'd1;
        end else if (tx_done_s) begin
          cnt_d   = 3'd0;
          state_d = IDLE;
        end else begin
          state_d = TX_DATA;
        end
      end
`ifdef UART_AVALON_MASTER_ACK_EN
      TX_ACK: begin
        if (!tx_busy_q && (cnt_q == 3'd0)) begin
          tx_start_s = 1'b1;
          tx_byte_s  = 8'h06;
          cnt_d      = 3'd1;
        end else if (tx_done_s) begin
          cnt_d   = 3'd0;
          state_d = IDLE;
        end else begin
          state_d = TX_ACK;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and Avalon output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      read_q  <= read_d;
      write_q <= write_d;
    end
  end

  assign uart_txd             = txd_q;
  assign avl.avalon_address   = addr_q;
  assign avl.avalon_read      = read_q;
  assign avl.avalon_write     = write_q;
  assign avl.avalon_writedata = wdata_q;
endmodule
